bram_playback_reader: RTL and testbench

//  Read-side counterpart to the BRAM capture address counter. On a trigger rising edge it

---
 rtl/bram_playback_reader.sv | 126 ++++++++++++
 tb/tb_bram_playback_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_playback_reader.sv
// BRAM playback reader: on a trigger edge, sweeps word addresses 0..count_max on the BRAM
// read port and streams the returned words out as registered samples with a valid flag.
module bram_playback_reader #(
  parameter int COUNT_WIDTH  = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   clken,
  input  logic                   trig,
  input  logic                   loop,
  input  logic [COUNT_WIDTH-1:0] count_max,
  output logic [31:0]            bram_addr,
  output logic                   bram_en,
  input  logic [DATA_WIDTH-1:0]  bram_rdata,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t                  r_state;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic [COUNT_WIDTH-1:0]  r_cmax;
  logic                    r_pending;
  logic                    r_trig_reg;
  logic                    r_bram_en;
  logic                    r_busy;
  logic                    r_done;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_dout_valid;

  logic w_edge;
  logic w_accept;
  logic w_at_end;
  logic w_restart;

  assign w_edge    = trig & ~r_trig_reg;
  assign w_accept  = r_bram_en & clken;
  assign w_at_end  = (r_count == r_cmax);
  assign w_restart = loop | r_pending | w_edge;

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the result is independent of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_cmax     <= '0;
      r_pending  <= 1'b0;
      r_trig_reg <= 1'b0;
      r_bram_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_trig_reg <= trig;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state   <= PLAY;
            r_bram_en <= 1'b1;
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_cmax    <= count_max;
            r_pending <= 1'b0;
          end
        end
        PLAY: begin
          if (w_accept && !w_at_end) begin
            r_count <= r_count + 1'b1;
          end else if (w_accept && w_at_end) begin
            r_count   <= '0;
            r_pending <= 1'b0;
            if (w_restart) begin
              r_cmax <= count_max;
            end else begin
              r_state   <= IDLE;
              r_bram_en <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          // An edge that does not coincide with the end-of-sweep accept is remembered once.
          if (w_edge && !(w_accept && w_at_end)) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid pipeline tracks accepted reads through the BRAM latency; rdata is captured at its tail.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_vpipe      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_vpipe[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
      r_dout_valid <= r_vpipe[READ_LATENCY-1];
      if (r_vpipe[READ_LATENCY-1]) begin
        r_dout <= bram_rdata;
      end
    end
  end

  assign bram_addr  = {{(30-COUNT_WIDTH){1'b0}}, r_count, 2'b00};
  assign bram_en    = r_bram_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_bram_playback_reader.sv
// Directed bench for bram_playback_reader: two instances (read latency 1 and 2) share stimulus;
// BRAM word i holds i+100.
module tb_bram_playback_reader;
  localparam int CW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          clken = 1'b0;
  logic          trig = 1'b0;
  logic          loop = 1'b0;
  logic [CW-1:0] count_max = '0;

  logic [31:0]   a1, a2;
  logic          en1, en2, v1, v2, busy1, busy2, done1, done2;
  logic [DW-1:0] rd1, rd2, p2a, d1, d2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  logic [31:0] addr_q[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int acc_cyc[$];
  int acc2_cyc[$];
  int v1_cyc[$];
  int v2_cyc[$];

  bram_playback_reader #(.COUNT_WIDTH(CW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut (
    .clk(clk), .aresetn(aresetn), .clken(clken), .trig(trig), .loop(loop),
    .count_max(count_max), .bram_addr(a1), .bram_en(en1), .bram_rdata(rd1),
    .dout(d1), .dout_valid(v1), .busy(busy1), .done(done1)
  );

  bram_playback_reader #(.COUNT_WIDTH(CW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .aresetn(aresetn), .clken(clken), .trig(trig), .loop(loop),
    .count_max(count_max), .bram_addr(a2), .bram_en(en2), .bram_rdata(rd2),
    .dout(d2), .dout_valid(v2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd1 <= (a1 >> 2) + 100;
    p2a <= (a2 >> 2) + 100;
    rd2 <= p2a;
  end

  always @(negedge clk) begin
    if (en1 && clken) begin
      addr_q.push_back(a1);
      acc_cyc.push_back(cyc);
    end
    if (en2 && clken) acc2_cyc.push_back(cyc);
    if (v1) begin
      q1.push_back(d1);
      v1_cyc.push_back(cyc);
    end
    if (v2) begin
      q2.push_back(d2);
      v2_cyc.push_back(cyc);
    end
    if (done1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    addr_q.delete(); q1.delete(); q2.delete();
    acc_cyc.delete(); acc2_cyc.delete(); v1_cyc.delete(); v2_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (6) step();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, {busy2, busy1}, 0);
  endtask

  // Accepted addresses follow 4*(i%period) spaced gap cycles apart; data follows i%period+100.
  task automatic expect_run(input string tag, input int n, input int period, input int gap);
    check({tag, "_n_acc"}, addr_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), addr_q[i], 4 * (i % period));
    for (int i = 1; i < n && i < acc_cyc.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), acc_cyc[i] - acc_cyc[i-1], gap);
    check({tag, "_n_q1"}, q1.size(), n);
    check({tag, "_n_q2"}, q2.size(), n);
    for (int i = 0; i < n && i < q1.size(); i++)
      check($sformatf("%s_d1_%0d", tag, i), q1[i], 100 + (i % period));
    for (int i = 0; i < n && i < q2.size(); i++)
      check($sformatf("%s_d2_%0d", tag, i), q2[i], 100 + (i % period));
    if (v1_cyc.size() > 0 && acc_cyc.size() > 0)
      check({tag, "_lat1"}, v1_cyc[0] - acc_cyc[0], 2);
    if (v2_cyc.size() > 0 && acc2_cyc.size() > 0)
      check({tag, "_lat2"}, v2_cyc[0] - acc2_cyc[0], 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_addr", a1, 0);
    check("rst_ctrl", {en1, busy1, done1, v1}, 0);
    check("rst_dout", d1, 0);
    aresetn = 1'b1;
    clken = 1'b1;
    step();
    check("post_rst_idle", {en1, busy1, done1, v1}, 0);

    // T1: one-shot, count_max change after start must be ignored
    clear();
    count_max = 3;
    pulse_trig();
    check("t1_busy_start", {busy1, done1}, 2'b10);
    count_max = 7;
    wait_done("t1");
    expect_run("t1", 4, 4, 1);

    // T2: two-word sweep, latency checked on both instances
    clear();
    count_max = 1;
    pulse_trig();
    wait_done("t2");
    expect_run("t2", 2, 2, 1);

    // T3: clken toggling during the sweep
    clear();
    count_max = 3;
    pulse_trig();
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      clken = (i % 2 == 0);
      step();
    end
    clken = 1'b1;
    wait_done("t3");
    expect_run("t3", 4, 4, 2);

    // T4: re-trigger at count=1 queues a second sweep
    clear();
    count_max = 3;
    pulse_trig();
    step();
    pulse_trig();
    wait_done("t4");
    expect_run("t4", 8, 4, 1);

    // T5: loop for exactly 9 accepts
    clear();
    count_max = 2;
    loop = 1'b1;
    pulse_trig();
    repeat (8) step();
    loop = 1'b0;
    wait_done("t5");
    expect_run("t5", 9, 3, 1);

    // T7: one-word sweep
    clear();
    count_max = 0;
    pulse_trig();
    wait_done("t7");
    expect_run("t7", 1, 1, 1);

    // T6: reset with reads in flight
    clear();
    count_max = 3;
    pulse_trig();
    step();
    step();
    check("t6_mid_addr", a1, 8);
    aresetn = 1'b0;
    #1;
    check("t6_rst_addr", a1, 0);
    check("t6_rst_ctrl", {en1, busy1, done1, v1, en2, busy2, done2, v2}, 0);
    check("t6_rst_dout", d1, 0);
    clear();
    step();
    aresetn = 1'b1;
    repeat (8) step();
    check("t6_no_acc", addr_q.size(), 0);
    check("t6_no_valid", q1.size() + q2.size(), 0);
    check("t6_idle", {busy1, busy2, done_cnt != 0}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
